// File: rtl/imem_load_controller_if.sv
// imem_load_controller_if
//   Bundles every non-clock/reset signal of the instruction-memory load
//   controller: the byte-stream loader request/handshake, the fetch-stage
//   PC/instruction path, the shared memory port and the status flags.
//
//   Modports:
//     slave  - the controller itself (takes requests, drives the memory port)
//     master - the environment (loader, fetch stage, memory, status observer)
//
//   Signals:
//     load_start, load_len, load_abort  loader requests into the controller
//     in_valid, in_data, in_ready       loader byte handshake
//     fetch_pc, fetch_instr, fetch_valid fetch-stage path
//     core_stall                        pipeline freeze
//     mem_addr, mem_we, mem_wdata       shared memory port out
//     mem_rdata                         combinational memory read data in
//     load_done, load_err               completion pulse and sticky error
interface imem_load_controller_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          load_start;
  logic [AW-1:0] load_len;
  logic          load_abort;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] fetch_pc;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          core_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          load_done;
  logic          load_err;

  modport slave (
    input  load_start, load_len, load_abort, in_valid, in_data,
           fetch_pc, mem_rdata,
    output in_ready, fetch_instr, fetch_valid, core_stall,
           mem_addr, mem_we, mem_wdata, load_done, load_err
  );

  modport master (
    output load_start, load_len, load_abort, in_valid, in_data,
           fetch_pc, mem_rdata,
    input  in_ready, fetch_instr, fetch_valid, core_stall,
           mem_addr, mem_we, mem_wdata, load_done, load_err
  );
endinterface

// File: rtl/imem_load_controller.sv
// imem_load_controller
//   Loads a program byte stream into the single-port instruction memory and
//   then hands that same address port to the fetch stage. The pipeline is
//   held (core_stall) from reset until a complete program has been written,
//   and again during any reload.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; returns to HALT and clears all state
//     bus    imem_load_controller_if.slave (loader, fetch, memory, status)
//
//   States: HALT -> LOAD -> SETTLE -> RUN, with RUN -> LOAD on reload and
//   LOAD -> HALT on abort.
module imem_load_controller #(
  parameter int DEPTH = 36,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input logic                  clk,
  input logic                  reset,
  imem_load_controller_if.slave bus
);

  typedef enum logic [1:0] {HALT, LOAD, SETTLE, RUN} state_t;

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] remaining;
  logic          load_err_q;
  logic          load_done_q;

  logic start_window;
  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic abort_hit;
  logic byte_take;
  logic pc_ok;
  logic fetch_oob;

  // A load request is only considered while idle or running; requests that
  // arrive mid-load or during SETTLE are silently dropped.
  assign start_window = (state == HALT) || (state == RUN);
  assign len_ok       = (bus.load_len != '0) && (bus.load_len <= DEPTH_W);
  assign start_ok     = bus.load_start && start_window && len_ok;
  assign start_bad    = bus.load_start && start_window && !len_ok;

  // Abort beats a byte presented in the same cycle, so that byte is neither
  // written nor counted.
  assign abort_hit = (state == LOAD) && bus.load_abort;
  assign byte_take = (state == LOAD) && bus.in_valid && !bus.load_abort;

  assign pc_ok     = bus.fetch_pc < DEPTH_W;
  assign fetch_oob = (state == RUN) && !pc_ok;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HALT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      HALT: begin
        if (start_ok) state_next = LOAD;
      end
      LOAD: begin
        if (abort_hit) begin
          state_next = HALT;
        end else if (byte_take && (remaining == AW'(1))) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        state_next = RUN;
      end
      RUN: begin
        if (start_ok) state_next = LOAD;
      end
      default: state_next = HALT;
    endcase
  end

  // Load counters and status flags. load_done is registered off SETTLE so it
  // lands exactly in the first RUN cycle. An accepted start clears the error
  // even if an out-of-range fetch happens in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      remaining   <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= (state == SETTLE);

      if (start_ok) begin
        remaining <= bus.load_len;
        wr_ptr    <= '0;
      end else if (byte_take) begin
        wr_ptr    <= wr_ptr + AW'(1);
        remaining <= remaining - AW'(1);
      end

      if (start_ok) begin
        load_err_q <= 1'b0;
      end else if (start_bad || abort_hit || fetch_oob) begin
        load_err_q <= 1'b1;
      end
    end
  end

  // Output logic: the memory port is muxed between the write pointer during
  // LOAD and the fetch PC during RUN; reads are combinational end to end.
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fetch_instr = '0;
    bus.fetch_valid = 1'b0;
    bus.core_stall  = 1'b1;
    bus.load_done   = load_done_q;
    bus.load_err    = load_err_q;
    unique case (state)
      HALT: begin
      end
      LOAD: begin
        bus.in_ready  = 1'b1;
        bus.mem_addr  = wr_ptr;
        bus.mem_wdata = bus.in_data;
        bus.mem_we    = byte_take;
      end
      SETTLE: begin
      end
      RUN: begin
        bus.core_stall = 1'b0;
        bus.mem_addr   = bus.fetch_pc;
        if (pc_ok) begin
          bus.fetch_instr = bus.mem_rdata;
          bus.fetch_valid = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/imem_load_controller.md
Name: imem_load_controller

Overview:
- Sequences program loading into the 8-bit, 36-entry instruction memory and shares that memory's single address port between the byte-stream loader and the fetch stage of the 4-stage pipeline.
- Holds the pipeline (core_stall) from reset until a valid program has been loaded, and during any reload.
- Releases the pipeline once the last byte is written, then forwards PC-indexed fetches.

Parameters:
DEPTH, 36, number of instruction memory entries
AW, 8, address/PC width
DW, 8, instruction width

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
load_start  input  1  single-cycle request to begin a program load
load_len  input  AW  byte count; sampled only when load_start is accepted
load_abort  input  1  abandons an in-progress load
in_valid  input  1  loader byte valid
in_data  input  DW  loader byte
in_ready  output  1  controller accepts a byte this cycle
fetch_pc  input  AW  PC from the fetch stage
fetch_instr  output  DW  instruction returned to fetch
fetch_valid  output  1  fetch_instr is valid
core_stall  output  1  freeze PC and pipeline registers
mem_addr  output  AW  shared memory address
mem_we  output  1  memory write enable
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory combinational read data
load_done  output  1  one-cycle pulse when a load completes
load_err  output  1  sticky error flag; cleared by reset or by an accepted load_start

Behaviour:
- States: HALT, LOAD, SETTLE, RUN. Reset enters HALT.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, fetch_instr=0, fetch_valid=0, load_done=0, load_err=0, core_stall=1. Internal wr_ptr=0, remaining=0.
- load_start acceptance:
  - Accepted only in HALT or RUN, and only when 1<=load_len<=DEPTH. On acceptance: remaining<=load_len, wr_ptr<=0, load_err<=0, next state LOAD.
  - If load_len=0 or load_len>DEPTH: request ignored, load_err<=1, state unchanged.
  - load_start in LOAD or SETTLE: ignored, no error.
- LOAD:
  - core_stall=1, in_ready=1, mem_addr=wr_ptr, mem_wdata=in_data, mem_we=in_valid (combinational; write takes effect in the same cycle).
  - On each accepted byte (in_valid & in_ready): wr_ptr+1, remaining-1.
  - When the accepted byte has remaining==1, next state is SETTLE.
  - in_valid low inserts wait cycles with no write and no counter change.
- load_abort:
  - In LOAD: next state HALT, no further writes, load_err<=1. Partial contents stay in memory but the core remains stalled.
  - In LOAD, abort has priority over a byte presented in the same cycle; that byte is not written.
  - Abort is ignored in every other state.
- SETTLE: one cycle; core_stall=1, in_ready=0, mem_we=0. Next state RUN. load_done=1 in the first RUN cycle only.
- RUN:
  - core_stall=0, in_ready=0, mem_we=0, mem_addr=fetch_pc.
  - If fetch_pc<DEPTH: fetch_instr=mem_rdata, fetch_valid=1.
  - If fetch_pc>=DEPTH: fetch_instr=0, fetch_valid=0, load_err<=1. The fetch is not wrapped.
  - Latency: fetch data is combinational from fetch_pc in RUN, zero cycles, matching the existing memory timing.
- Outside RUN: fetch_valid=0, fetch_instr=0.
- Reload from RUN: core_stall rises in the cycle after load_start is accepted. The pipeline must not advance while core_stall=1.
- Asynchronous reset mid-LOAD: immediate return to HALT. Memory contents are not cleared by this block.
- Simultaneous load_start and load_abort in RUN: load_start wins, since abort only applies in LOAD.

Test Plan:
1. Reset, then load_start with load_len=6 and bytes 23,61,02,C1,43,14 back-to-back -> writes at addresses 0..5 in 6 consecutive cycles, one SETTLE cycle, load_done pulse, core_stall falls; fetch_pc=3 returns C1 with fetch_valid=1.
2. Load of 4 bytes with in_valid low for 2 cycles after byte 2 -> no writes during the gap, wr_ptr holds at 2, completion occurs 2 cycles later than case 1 would give.
3. load_len=0, then load_len=37 -> state unchanged, load_err=1; a following valid load_start clears load_err.
4. load_abort asserted on the 3rd byte of a 5-byte load -> only addresses 0 and 1 written, HALT, core_stall stays 1, load_err=1.
5. In RUN, fetch_pc=40 -> fetch_valid=0, fetch_instr=00, load_err=1; fetch_pc=0 then returns 23.
6. Reset asserted mid-LOAD with clk stopped -> outputs take reset values immediately; the next load must start at address 0.
